temp_ascii_formatter: RTL and testbench

Converts one DS18B20 temperature reading (magnitude in 1/16 °C plus sign bit) into a fixed-width ASCII record such as "+025.1" CR LF and streams it byte by byte to a byte-wide UART transmitter over a valid/ready handshake. It sits between the DS18B20 driver's outputs (temp_data and sign) and the UART transmitter, so the serial output becomes human-readable text instead of raw binary. It is triggered by the same periodic 1 s trigger pulse.

---
 rtl/temp_ascii_formatter.sv | 152 +++++++++++++++
 tb/tb_temp_ascii_formatter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/temp_ascii_formatter.sv
// temp_ascii_formatter: turns one DS18B20 reading (1/16 degC magnitude + sign)
// into a fixed-width ASCII record such as "+025.1" and streams it byte by byte
// over a valid/ready handshake to a UART transmitter.
// Build option: define TEMP_FMT_CRLF_EN to end each record with CR LF
// (8 bytes); otherwise the record ends with LF only (7 bytes).
`timescale 1ns/1ps

module temp_ascii_formatter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] temp_data,
    input  logic        sign,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SCALE   = 2'd1;
    localparam logic [1:0] CONVERT = 2'd2;
    localparam logic [1:0] SEND    = 2'd3;

`ifdef TEMP_FMT_CRLF_EN
    localparam logic [2:0] LAST_IDX = 3'd7;
`else
    localparam logic [2:0] LAST_IDX = 3'd6;
`endif

    logic [1:0]  state_q,    state_d;
    logic [15:0] mag_q,      mag_d;
    logic        sign_q,     sign_d;
    logic        neg_q,      neg_d;
    logic [13:0] bin_q,      bin_d;
    logic [15:0] bcd_q,      bcd_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [2:0]  byte_idx_q, byte_idx_d;

    logic [18:0] scaled;
    logic [15:0] tenths;
    logic [15:0] tenths_clamped;
    logic [15:0] bcd_adj;

    // Double-dabble correction: a BCD digit of 5 or more gets +3 before shifting.
    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    // Next-state logic: latch, scale to tenths, convert to BCD, then stream bytes.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        sign_d     = sign_q;
        neg_d      = neg_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;

        // mag * 10/16 rounded half-up, written as (mag*5 + 4) >> 3
        scaled         = {3'b000, mag_q} * 19'd5 + 19'd4;
        tenths         = scaled[18:3];
        tenths_clamped = (tenths > 16'd9999) ? 16'd9999 : tenths;

        bcd_adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                   add3(bcd_q[7:4]),   add3(bcd_q[3:0])};

        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d   = temp_data;
                    sign_d  = sign;
                    state_d = SCALE;
                end
            end
            SCALE: begin
                bin_d     = tenths_clamped[13:0];
                neg_d     = sign_q && (tenths_clamped != 16'd0);
                bcd_d     = '0;
                bit_cnt_d = '0;
                state_d   = CONVERT;
            end
            CONVERT: begin
                bcd_d     = {bcd_adj[14:0], bin_q[13]};
                bin_d     = {bin_q[12:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd13) begin
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
            end
            default: begin // SEND
                if (tx_ready) begin
                    if (byte_idx_q == LAST_IDX) begin
                        byte_idx_d = '0;
                        state_d    = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            sign_q     <= 1'b0;
            neg_q      <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            sign_q     <= sign_d;
            neg_q      <= neg_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Outputs decode straight from state so reset clears them in the same cycle.
    always_comb begin
        busy     = (state_q != IDLE);
        tx_valid = (state_q == SEND);
        tx_data  = 8'h00;
        if (state_q == SEND) begin
            case (byte_idx_q)
                3'd0:    tx_data = neg_q ? 8'h2D : 8'h2B;
                3'd1:    tx_data = {4'h3, bcd_q[15:12]};
                3'd2:    tx_data = {4'h3, bcd_q[11:8]};
                3'd3:    tx_data = {4'h3, bcd_q[7:4]};
                3'd4:    tx_data = 8'h2E;
                3'd5:    tx_data = {4'h3, bcd_q[3:0]};
`ifdef TEMP_FMT_CRLF_EN
                3'd6:    tx_data = 8'h0D;
`else
                3'd6:    tx_data = 8'h0A;
`endif
                default: tx_data = 8'h0A;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_ascii_formatter.sv
// Testbench for temp_ascii_formatter: randomized readings, random or stalled
// tx_ready, ignored start pulses, back-to-back records and mid-record reset,
// all checked against an arithmetic model of the ASCII record.
`timescale 1ns/1ps

module tb_temp_ascii_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] temp_data;
    logic        sign;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

`ifdef TEMP_FMT_CRLF_EN
    localparam int REC_LEN = 8;
`else
    localparam int REC_LEN = 7;
`endif

    logic [7:0] exp_bytes [8];

    always #5 clk = ~clk;

    temp_ascii_formatter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .temp_data (temp_data),
        .sign      (sign),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: tenths of a degree with half-up rounding, clamped, decimal digits.
    task automatic build_expected(input int t, input bit s);
        int tenths;
        tenths = (t * 10 + 8) / 16;
        if (tenths > 9999) tenths = 9999;
        exp_bytes[0] = (s && tenths != 0) ? 8'h2D : 8'h2B;
        exp_bytes[1] = 8'(48 + tenths / 1000);
        exp_bytes[2] = 8'(48 + (tenths / 100) % 10);
        exp_bytes[3] = 8'(48 + (tenths / 10) % 10);
        exp_bytes[4] = 8'h2E;
        exp_bytes[5] = 8'(48 + tenths % 10);
        if (REC_LEN == 8) begin
            exp_bytes[6] = 8'h0D;
            exp_bytes[7] = 8'h0A;
        end else begin
            exp_bytes[6] = 8'h0A;
            exp_bytes[7] = 8'h00;
        end
    endtask

    // Called at a negedge; start is raised for the current cycle (T).
    // mode 0: ready always 1, 1: random ready, 2: stall stall_len cycles on stall_idx.
    // Returns at the negedge where busy has just been seen low.
    task automatic run_record(input int t, input bit s, input int mode,
                              input int stall_idx, input int stall_len,
                              input bit start_at_last);
        int idx = 0;
        int stall_cnt = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        bit done = 1'b0;
        bit rdy;
        build_expected(t, s);
        temp_data = 16'(t);
        sign      = s;
        start     = 1'b1;
        tx_ready  = 1'($urandom_range(0, 1));
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            start     = (k == 5);
            temp_data = 16'($urandom);
            sign      = 1'($urandom_range(0, 1));
            tx_ready  = 1'($urandom_range(0, 1));
            check("busy_conv", 32'(busy), 1);
            check("valid_conv", 32'(tx_valid), 0);
        end
        for (int k = 16; k < 416 && !done; k++) begin
            @(negedge clk);
            start = (k == 20);
            if (idx < REC_LEN) begin
                check("valid_send", 32'(tx_valid), 1);
                check("busy_send", 32'(busy), 1);
                if (prev_stall) check("hold_data", 32'(tx_data), 32'(prev_data));
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (idx == stall_idx && stall_cnt < stall_len) begin
                            rdy = 1'b0;
                            stall_cnt++;
                        end else begin
                            rdy = 1'b1;
                        end
                    end
                endcase
                tx_ready = rdy;
                if (rdy) begin
                    check("byte", 32'(tx_data), 32'(exp_bytes[idx]));
                    idx++;
                    if (start_at_last && idx == REC_LEN) start = 1'b1;
                end
                prev_stall = !rdy;
                prev_data  = tx_data;
            end else begin
                check("busy_end", 32'(busy), 0);
                check("valid_end", 32'(tx_valid), 0);
                check("data_end", 32'(tx_data), 0);
                if (mode == 0) check("end_cycle", 32'(k), 32'(16 + REC_LEN));
                done     = 1'b1;
                start    = 1'b0;
                tx_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) check("timeout", 0, 1);
        if (start_at_last) begin
            @(negedge clk);
            check("late_start_ignored", 32'(busy), 0);
        end
    endtask

    // Start a record, then assert reset while byte index 4 is on offer.
    task automatic reset_mid_send();
        temp_data = 16'd401;
        sign      = 1'b0;
        start     = 1'b1;
        tx_ready  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start    = 1'b0;
            tx_ready = (k < 20);
        end
        check("pre_reset_data", 32'(tx_data), 32'h2E);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(tx_data), 0);
        @(negedge clk);
        check("rst_hold_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst       = 1'b1;
        start     = 1'b0;
        temp_data = '0;
        sign      = 1'b0;
        tx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(tx_valid), 0);
        check("reset_data", 32'(tx_data), 0);
        rst      = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        check("idle_ready_no_effect", 32'(tx_valid), 0);

        run_record(401,   1'b0, 0, 0, 0, 1'b0); @(negedge clk);
        run_record(168,   1'b1, 0, 0, 0, 1'b0); @(negedge clk);
        run_record(0,     1'b1, 0, 0, 0, 1'b0); @(negedge clk);
        run_record(1,     1'b1, 0, 0, 0, 1'b0); @(negedge clk);
        run_record(65535, 1'b0, 0, 0, 0, 1'b0); @(negedge clk);
        run_record(2000,  1'b0, 0, 0, 0, 1'b0); @(negedge clk);
        run_record(15998, 1'b0, 0, 0, 0, 1'b0); @(negedge clk);
        run_record(15999, 1'b1, 0, 0, 0, 1'b0); @(negedge clk);

        run_record(401,   1'b0, 2, 3, 5, 1'b0); @(negedge clk);
        run_record(2000,  1'b1, 0, 0, 0, 1'b1); @(negedge clk);

        // back-to-back: second start lands on the cycle after busy falls
        run_record(168,   1'b1, 0, 0, 0, 1'b0);
        run_record(401,   1'b0, 0, 0, 0, 1'b0); @(negedge clk);

        reset_mid_send();
        run_record(401,   1'b0, 0, 0, 0, 1'b0); @(negedge clk);

        repeat (40) begin
            case ($urandom_range(0, 3))
                0: t = int'($urandom_range(0, 65535));
                1: t = int'($urandom_range(15990, 16010));
                2: t = int'($urandom_range(0, 40));
                default: t = int'($urandom_range(0, 2000));
            endcase
            run_record(t, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, REC_LEN - 1)), int'($urandom_range(1, 6)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
